// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light controller and the display path.
// The phase enum is the controller's internal phase; the DISP_* constants
// are the 2-bit codes the dot-matrix display decodes. FLASH is internal-only
// and is presented to the display as YELLOW.
package tlc_pkg;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_RED    = 2'b10,
    PH_FLASH  = 2'b11
  } phase_e;

  localparam logic [1:0] DISP_GREEN  = 2'b00;
  localparam logic [1:0] DISP_YELLOW = 2'b01;
  localparam logic [1:0] DISP_RED    = 2'b10;

  // Map an internal phase to the display code; FLASH shows as YELLOW so the
  // display never sees 2'b11.
  function automatic logic [1:0] disp_code(input phase_e ph);
    logic [1:0] code;
    case (ph)
      PH_GREEN:  code = DISP_GREEN;
      PH_YELLOW: code = DISP_YELLOW;
      PH_RED:    code = DISP_RED;
      default:   code = DISP_YELLOW;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/count_bin2bcd.sv
// Combinational 7-bit binary to two-digit BCD converter for the countdown.
// Valid for inputs 0..99.
//   bin  : binary value
//   tens : BCD tens digit
//   ones : BCD ones digit
module count_bin2bcd (
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  // Tens digit by compare ladder; ones digit is the remainder. Only the low
  // nibble of 10*tens matters since the remainder is always below 10, and
  // 10*t mod 16 == (8*t + 2*t) mod 16.
  always_comb begin
    if (bin >= 7'd90) begin
      tens = 4'd9;
    end else if (bin >= 7'd80) begin
      tens = 4'd8;
    end else if (bin >= 7'd70) begin
      tens = 4'd7;
    end else if (bin >= 7'd60) begin
      tens = 4'd6;
    end else if (bin >= 7'd50) begin
      tens = 4'd5;
    end else if (bin >= 7'd40) begin
      tens = 4'd4;
    end else if (bin >= 7'd30) begin
      tens = 4'd3;
    end else if (bin >= 7'd20) begin
      tens = 4'd2;
    end else if (bin >= 7'd10) begin
      tens = 4'd1;
    end else begin
      tens = 4'd0;
    end
    ones = bin[3:0] - ({tens[0], 3'b000} + {tens[2:0], 1'b0});
  end

endmodule

// File: rtl/traffic_light_controller.sv
// Traffic-light phase sequencer driven by a 1 Hz enable.
// Cycles GREEN -> YELLOW -> RED, counting each phase down DUR..1. A
// pedestrian request shortens green to PED_MIN remaining ticks, pause holds
// the countdown, and night forces a flashing-yellow mode.
//   clk, rst_n          : clock, async active-low reset
//   tick_1hz            : one-clk enable pulse per second
//   ped_req             : debounced pedestrian button level
//   pause               : hold countdown
//   night               : flashing-yellow mode
//   state               : display phase code (00 G, 01 Y, 10 R)
//   light_r/_y/_g       : lamp drives
//   cnt_tens/cnt_ones   : BCD remaining count
//   ped_wait            : pedestrian request pending
module traffic_light_controller
  import tlc_pkg::*;
#(
  parameter int GREEN_TIME  = 15,
  parameter int YELLOW_TIME = 5,
  parameter int RED_TIME    = 10,
  parameter int PED_MIN     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       ped_req,
  input  logic       pause,
  input  logic       night,
  output logic [1:0] state,
  output logic       light_r,
  output logic       light_y,
  output logic       light_g,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_ones,
  output logic       ped_wait
);

  localparam logic [6:0] GREEN_CNT  = 7'(GREEN_TIME);
  localparam logic [6:0] YELLOW_CNT = 7'(YELLOW_TIME);
  localparam logic [6:0] RED_CNT    = 7'(RED_TIME);
  localparam logic [6:0] PED_CNT    = 7'(PED_MIN);

  phase_e     phase_r;
  logic [6:0] count_r;
  logic       ped_pending_r;
  logic       blink_r;

  logic       ped_hit_s;
  logic       shorten_s;

  // A request seen this edge counts toward shortening immediately, so a
  // press coinciding with a tick shortens instead of decrementing.
  always_comb begin
    ped_hit_s = ped_req && ((phase_r == PH_GREEN) || (phase_r == PH_YELLOW));
    shorten_s = (phase_r == PH_GREEN) && (ped_pending_r || ped_hit_s) &&
                (count_r > PED_CNT);
  end

  // Phase FSM, countdown, pedestrian latch and flash blink.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r       <= PH_GREEN;
      count_r       <= GREEN_CNT;
      ped_pending_r <= 1'b0;
      blink_r       <= 1'b0;
    end else if (night) begin
      phase_r       <= PH_FLASH;
      count_r       <= 7'd0;
      ped_pending_r <= 1'b0;
      // Toggle only once already flashing; blink is 0 on entry.
      if ((phase_r == PH_FLASH) && tick_1hz) begin
        blink_r <= ~blink_r;
      end else begin
        blink_r <= blink_r;
      end
    end else if (phase_r == PH_FLASH) begin
      phase_r <= PH_RED;
      count_r <= RED_CNT;
      blink_r <= 1'b0;
    end else begin
      if (ped_hit_s) begin
        ped_pending_r <= 1'b1;
      end
      if (shorten_s) begin
        count_r <= PED_CNT;
      end else if (tick_1hz && !pause) begin
        if (count_r > 7'd1) begin
          count_r <= count_r - 7'd1;
        end else begin
          case (phase_r)
            PH_GREEN: begin
              phase_r <= PH_YELLOW;
              count_r <= YELLOW_CNT;
            end
            PH_YELLOW: begin
              // Later assignment wins over a same-edge request latch.
              phase_r       <= PH_RED;
              count_r       <= RED_CNT;
              ped_pending_r <= 1'b0;
            end
            default: begin
              phase_r <= PH_GREEN;
              count_r <= GREEN_CNT;
            end
          endcase
        end
      end
    end
  end

  // Lamp and display decode straight from the registers.
  always_comb begin
    state    = disp_code(phase_r);
    ped_wait = ped_pending_r;
    case (phase_r)
      PH_GREEN: begin
        light_r = 1'b0;
        light_y = 1'b0;
        light_g = 1'b1;
      end
      PH_YELLOW: begin
        light_r = 1'b0;
        light_y = 1'b1;
        light_g = 1'b0;
      end
      PH_RED: begin
        light_r = 1'b1;
        light_y = 1'b0;
        light_g = 1'b0;
      end
      default: begin
        light_r = 1'b0;
        light_y = blink_r;
        light_g = 1'b0;
      end
    endcase
  end

  count_bin2bcd u_bcd (
    .bin  (count_r),
    .tens (cnt_tens),
    .ones (cnt_ones)
  );

endmodule

// File: tb/tb_traffic_light_controller.sv
// Bench for traffic_light_controller: directed scenarios plus a randomized
// run compared cycle-by-cycle against a behavioural model of the phase rules.
module tb_traffic_light_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       ped_req = 1'b0;
  logic       pause = 1'b0;
  logic       night = 1'b0;
  logic [1:0] state;
  logic       light_r, light_y, light_g;
  logic [3:0] cnt_tens, cnt_ones;
  logic       ped_wait;
  logic [13:0] dut_out;

  int checks = 0;
  int errors = 0;

  // Model: phase 0=green 1=yellow 2=red 3=flash, plain integer remaining count.
  int m_phase;
  int m_cnt;
  bit m_ped;
  bit m_blink;

  traffic_light_controller dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_1hz (tick_1hz),
    .ped_req  (ped_req),
    .pause    (pause),
    .night    (night),
    .state    (state),
    .light_r  (light_r),
    .light_y  (light_y),
    .light_g  (light_g),
    .cnt_tens (cnt_tens),
    .cnt_ones (cnt_ones),
    .ped_wait (ped_wait)
  );

  assign dut_out = {state, light_r, light_y, light_g, cnt_tens, cnt_ones, ped_wait};

  always #5 clk = ~clk;

  function automatic int dur(input int p);
    case (p)
      0:       return 15;
      1:       return 5;
      default: return 10;
    endcase
  endfunction

  // Pack expected outputs: {state, r, y, g, tens, ones, ped_wait}.
  function automatic logic [13:0] pack(input int st, input bit r, input bit y,
                                       input bit g, input int cnt, input bit pw);
    logic [1:0] s2;
    logic [3:0] t4;
    logic [3:0] o4;
    s2 = 2'(st);
    t4 = 4'(cnt / 10);
    o4 = 4'(cnt % 10);
    return {s2, r, y, g, t4, o4, pw};
  endfunction

  function automatic logic [13:0] model_out();
    if (m_phase == 3) return pack(1, 1'b0, m_blink, 1'b0, 0, m_ped);
    return pack(m_phase, m_phase == 2, m_phase == 1, m_phase == 0, m_cnt, m_ped);
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_cnt   = 15;
    m_ped   = 1'b0;
    m_blink = 1'b0;
  endtask

  // Drive one clock with the given inputs and advance the model.
  task automatic step(input bit t, input bit p, input bit pa, input bit n);
    bit req_ok;
    tick_1hz = t;
    ped_req  = p;
    pause    = pa;
    night    = n;
    @(posedge clk);
    if (n) begin
      if (m_phase == 3 && t) m_blink = !m_blink;
      m_phase = 3;
      m_cnt   = 0;
      m_ped   = 1'b0;
    end else if (m_phase == 3) begin
      m_phase = 2;
      m_cnt   = dur(2);
      m_blink = 1'b0;
    end else begin
      req_ok = p && (m_phase != 2);
      if (req_ok) m_ped = 1'b1;
      if (m_phase == 0 && m_ped && m_cnt > 3) begin
        m_cnt = 3;
      end else if (t && !pa) begin
        if (m_cnt > 1) begin
          m_cnt = m_cnt - 1;
        end else begin
          m_phase = (m_phase + 1) % 3;
          m_cnt   = dur(m_phase);
          if (m_phase == 2) m_ped = 1'b0;
        end
      end
    end
    #1;
    tick_1hz = 1'b0;
    ped_req  = 1'b0;
  endtask

  // n ticks each followed by an idle cycle; no checking.
  task automatic ticks(input int n, input bit pa);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, pa, 1'b0);
      step(1'b0, 1'b0, pa, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    tick_1hz = 1'b0;
    ped_req  = 1'b0;
    pause    = 1'b0;
    night    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (dut_out !== pack(0, 1'b0, 1'b0, 1'b1, 15, 1'b0)) begin
      errors++;
      $display("FAIL reset_outputs got %b exp %b", dut_out, pack(0, 1'b0, 1'b0, 1'b1, 15, 1'b0));
    end
    rst_n = 1'b1;
    model_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (dut_out !== pack(0, 1'b0, 1'b0, 1'b1, 15, 1'b0)) begin
      errors++;
      $display("FAIL reset_idle got %b exp %b", dut_out, pack(0, 1'b0, 1'b0, 1'b1, 15, 1'b0));
    end
  endtask

  task automatic test_normal_cycle();
    logic [13:0] exp_v;
    do_reset();
    for (int i = 1; i <= 30; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (dut_out !== model_out()) begin
        errors++;
        $display("FAIL cycle_tick%0d got %b exp %b", i, dut_out, model_out());
      end
      if (i == 15 || i == 20 || i == 30) begin
        if (i == 15) exp_v = pack(1, 1'b0, 1'b1, 1'b0, 5, 1'b0);
        else if (i == 20) exp_v = pack(2, 1'b1, 1'b0, 1'b0, 10, 1'b0);
        else exp_v = pack(0, 1'b0, 1'b0, 1'b1, 15, 1'b0);
        checks++;
        if (dut_out !== exp_v) begin
          errors++;
          $display("FAIL cycle_phase_at%0d got %b exp %b", i, dut_out, exp_v);
        end
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_ped_shorten();
    do_reset();
    ticks(3, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (dut_out !== pack(0, 1'b0, 1'b0, 1'b1, 3, 1'b1)) begin
      errors++;
      $display("FAIL ped_shorten got %b exp %b", dut_out, pack(0, 1'b0, 1'b0, 1'b1, 3, 1'b1));
    end
    ticks(3, 1'b0);
    checks++;
    if (dut_out !== pack(1, 1'b0, 1'b1, 1'b0, 5, 1'b1)) begin
      errors++;
      $display("FAIL ped_yellow got %b exp %b", dut_out, pack(1, 1'b0, 1'b1, 1'b0, 5, 1'b1));
    end
    ticks(5, 1'b0);
    checks++;
    if (dut_out !== pack(2, 1'b1, 1'b0, 1'b0, 10, 1'b0)) begin
      errors++;
      $display("FAIL ped_clear_red got %b exp %b", dut_out, pack(2, 1'b1, 1'b0, 1'b0, 10, 1'b0));
    end
  endtask

  task automatic test_ped_boundary();
    do_reset();
    ticks(5, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (dut_out !== pack(0, 1'b0, 1'b0, 1'b1, 3, 1'b1)) begin
      errors++;
      $display("FAIL ped_same_tick got %b exp %b", dut_out, pack(0, 1'b0, 1'b0, 1'b1, 3, 1'b1));
    end
    do_reset();
    ticks(13, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (dut_out !== pack(0, 1'b0, 1'b0, 1'b1, 2, 1'b1)) begin
      errors++;
      $display("FAIL ped_at_two got %b exp %b", dut_out, pack(0, 1'b0, 1'b0, 1'b1, 2, 1'b1));
    end
    ticks(2, 1'b0);
    checks++;
    if (dut_out !== pack(1, 1'b0, 1'b1, 1'b0, 5, 1'b1)) begin
      errors++;
      $display("FAIL ped_at_two_expiry got %b exp %b", dut_out, pack(1, 1'b0, 1'b1, 1'b0, 5, 1'b1));
    end
    // Shortening still applies while paused.
    do_reset();
    ticks(2, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (dut_out !== pack(0, 1'b0, 1'b0, 1'b1, 3, 1'b1)) begin
      errors++;
      $display("FAIL ped_during_pause got %b exp %b", dut_out, pack(0, 1'b0, 1'b0, 1'b1, 3, 1'b1));
    end
  endtask

  task automatic test_pause();
    do_reset();
    ticks(23, 1'b0);
    checks++;
    if (dut_out !== pack(2, 1'b1, 1'b0, 1'b0, 7, 1'b0)) begin
      errors++;
      $display("FAIL pause_setup got %b exp %b", dut_out, pack(2, 1'b1, 1'b0, 1'b0, 7, 1'b0));
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      checks++;
      if (dut_out !== pack(2, 1'b1, 1'b0, 1'b0, 7, 1'b0)) begin
        errors++;
        $display("FAIL pause_hold%0d got %b exp %b", i, dut_out, pack(2, 1'b1, 1'b0, 1'b0, 7, 1'b0));
      end
      step(1'b0, 1'b0, 1'b1, 1'b0);
    end
    ticks(7, 1'b0);
    checks++;
    if (dut_out !== pack(0, 1'b0, 1'b0, 1'b1, 15, 1'b0)) begin
      errors++;
      $display("FAIL pause_release got %b exp %b", dut_out, pack(0, 1'b0, 1'b0, 1'b1, 15, 1'b0));
    end
  endtask

  task automatic test_night();
    bit y_exp;
    do_reset();
    ticks(17, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (dut_out !== pack(1, 1'b0, 1'b0, 1'b0, 0, 1'b0)) begin
      errors++;
      $display("FAIL night_enter got %b exp %b", dut_out, pack(1, 1'b0, 1'b0, 1'b0, 0, 1'b0));
    end
    y_exp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      // pause is set on odd ticks; it must not stop the blink.
      step(1'b1, 1'b0, i[0], 1'b1);
      y_exp = !y_exp;
      checks++;
      if (dut_out !== pack(1, 1'b0, y_exp, 1'b0, 0, 1'b0)) begin
        errors++;
        $display("FAIL night_blink%0d got %b exp %b", i, dut_out, pack(1, 1'b0, y_exp, 1'b0, 0, 1'b0));
      end
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (dut_out !== pack(2, 1'b1, 1'b0, 1'b0, 10, 1'b0)) begin
      errors++;
      $display("FAIL night_exit got %b exp %b", dut_out, pack(2, 1'b1, 1'b0, 1'b0, 10, 1'b0));
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    ticks(22, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_out !== pack(0, 1'b0, 1'b0, 1'b1, 15, 1'b0)) begin
      errors++;
      $display("FAIL async_reset got %b exp %b", dut_out, pack(0, 1'b0, 1'b0, 1'b1, 15, 1'b0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    bit n_lvl;
    n_lvl = 1'b0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) n_lvl = !n_lvl;
      step($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 5) == 0, n_lvl);
      checks++;
      if (dut_out !== model_out()) begin
        errors++;
        $display("FAIL random_cycle%0d got %b exp %b", i, dut_out, model_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal_cycle();
    test_ped_shorten();
    test_ped_boundary();
    test_pause();
    test_night();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
